npu_mac: RTL and testbench
==========================

# npu_mac

Single-lane multiply-accumulate unit for the NPU MNIST classifier datapath. Each enabled clock it multiplies an activation `a` by a weight `b` and adds the product into an internal accumulator. `result` presents the accumulator plus the neuron bias `BIAS_IN`. Neuron-array control instantiates one per output neuron and sequences it with `EN_MAC`, `CLR_MAC` and `RST_MAC`.

## Interface
Parameters:
- `DATA_W`, 8: width of `a`, `b` and `BIAS_IN`.
- `ACC_W`, 16: width of the accumulator and `result`; must be ≥ 2·`DATA_W`.
- `SIGNED_MODE`, 0: 0 means all operands unsigned; 1 means two's-complement `a`, `b`, `BIAS_IN`, accumulator and `result`.
- `SATURATE`, 1: 1 clamps on overflow; 0 wraps modulo 2^`ACC_W`.

Ports:
- `CLKEXT`, in, 1: the single clock; rising-edge active.
- `RST_MAC`, in, 1: asynchronous, active-low reset.
- `EN_MAC`, in, 1: accumulate enable, sampled on the rising edge.
- `CLR_MAC`, in, 1: synchronous accumulator clear.
- `a`, in, `DATA_W`: activation operand.
- `b`, in, `DATA_W`: weight operand.
- `BIAS_IN`, in, `DATA_W`: neuron bias, extended and added at the output.
- `result`, out, `ACC_W`: accumulator + `BIAS_IN`.
- `OVF`, out, 1: sticky overflow flag.

## Operation
- Internal register `acc` is `ACC_W` bits. Product `p = a*b` is 2·`DATA_W` bits, extended to `ACC_W` (zero-extend if `SIGNED_MODE`=0, sign-extend if 1).
- Clock-edge priority (`RST_MAC` high), highest first:
  - `CLR_MAC`=1: `acc`←0 and `OVF`←0.
  - `EN_MAC`=1: `acc`←sat(`acc`+`p`).
  - Otherwise `acc` and `OVF` hold.
- Output path is combinational: `result` = sat(`acc` + ext(`BIAS_IN`)), using the same extension rule as `p`. `result` therefore equals `BIAS_IN` whenever `acc`=0.
- Saturation, `SATURATE`=1:
  - Unsigned: clamp to 2^`ACC_W`−1.
  - Signed: clamp to +2^(`ACC_W`−1)−1 or −2^(`ACC_W`−1).
- With `SATURATE`=0, both additions wrap.
- `OVF` is set on any clock where the accumulate addition overflows, whether clamped or wrapped. It stays set until reset or `CLR_MAC`.
- `OVF` is also asserted combinationally while the output-path addition overflows.
- `BIAS_IN` is not registered; it must be held stable by the controller for the duration of a neuron computation.

## Timing
- `RST_MAC` low: `acc`=0 and `OVF` register=0 immediately, independent of the clock. During reset `result` = ext(`BIAS_IN`), saturated if needed.
- Reset asserted mid-accumulation discards the partial sum. The first edge after deassertion with `EN_MAC`=1 accumulates normally.
- Latency: an operand pair sampled on edge N is reflected in `result` after edge N, so one cycle of latency. Throughput is one MAC per clock.
- `EN_MAC`=0: `result` changes only if `BIAS_IN` changes.
- `CLR_MAC` and `EN_MAC` both high on the same edge: clear wins and the product is dropped.
- Operands only need to be stable around the sampling edge. There is no handshake and no backpressure.

## Test plan
- Reset value:
  - Stimulus: `RST_MAC`=0, `BIAS_IN`=10.
  - Required: `result`=10 and `OVF`=0 without any clock edge. Changing `BIAS_IN` to 5 during reset gives `result`=5.
- Accumulate:
  - Stimulus: release reset with `BIAS_IN`=10; edge 1 with `EN_MAC`=1, a=3, b=4; edge 2 with a=2, b=5.
  - Required: `result`=22 after edge 1 and 32 after edge 2.
- Hold:
  - Stimulus: after the accumulate case, `EN_MAC`=0 for 3 edges with a=9, b=9.
  - Required: `result` stays 32.
- Async reset mid-run:
  - Stimulus: drop `RST_MAC` between edges; release; edge with `EN_MAC`=1, a=1, b=7, `BIAS_IN`=10.
  - Required: `result`=10 during reset and 17 after the edge.
- Clear priority:
  - Stimulus: `CLR_MAC`=1 and `EN_MAC`=1 with a=3, b=3.
  - Required: `result`=`BIAS_IN` after the edge.
- Saturation (defaults):
  - Stimulus: `BIAS_IN`=0; accumulate 255·255 twice.
  - Required: `result`=65535 after the second edge; `OVF`=1 and stays 1 until `CLR_MAC`.
  - With `SATURATE`=0, the same stimulus gives `result`=64514.
  - With `SIGNED_MODE`=1: a=−128, b=−128 accumulated twice clamps to 32767.

Source files
------------

// File: rtl/npu_mac.sv
// rtl/npu_mac.sv - Single-lane multiply-accumulate with bias add, saturation and sticky overflow.
module npu_mac #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter bit SIGNED_MODE = 1'b0,
    parameter bit SATURATE    = 1'b1
) (
    input  logic              CLKEXT,
    input  logic              RST_MAC,
    input  logic              EN_MAC,
    input  logic              CLR_MAC,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] BIAS_IN,
    output logic [ACC_W-1:0]  result,
    output logic              OVF
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = ACC_W + 1;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [PW-1:0]    w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_bias_ext;
    logic [ACC_W:0]   w_acc_sum;
    logic [ACC_W:0]   w_out_sum;

    // Returns {overflow, clamped-or-wrapped sum}; the extra bit makes the true sign/carry visible.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
        logic [ACC_W:0]   s;
        logic [ACC_W-1:0] lim;
        logic             ovf;
        if (SIGNED_MODE) begin
            s   = SW'($signed(x)) + SW'($signed(y));
            ovf = s[ACC_W] ^ s[ACC_W-1];
            lim = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            s   = {1'b0, x} + {1'b0, y};
            ovf = s[ACC_W];
            lim = '1;
        end
        return {ovf, (ovf && SATURATE) ? lim : s[ACC_W-1:0]};
    endfunction

    always_comb begin
        w_prod     = '0;
        w_prod_ext = '0;
        w_bias_ext = '0;
        if (SIGNED_MODE) begin
            w_prod     = PW'($signed(a)) * PW'($signed(b));
            w_prod_ext = ACC_W'($signed(w_prod));
            w_bias_ext = ACC_W'($signed(BIAS_IN));
        end else begin
            w_prod     = PW'(a) * PW'(b);
            w_prod_ext = ACC_W'(w_prod);
            w_bias_ext = ACC_W'(BIAS_IN);
        end
    end

    assign w_acc_sum = sat_add(r_acc, w_prod_ext);
    assign w_out_sum = sat_add(r_acc, w_bias_ext);

    always_ff @(posedge CLKEXT or negedge RST_MAC) begin
        if (!RST_MAC) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (CLR_MAC) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (EN_MAC) begin
            r_acc <= w_acc_sum[ACC_W-1:0];
            if (w_acc_sum[ACC_W]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign result = w_out_sum[ACC_W-1:0];
    assign OVF    = r_ovf | w_out_sum[ACC_W];

endmodule

// File: tb/tb_npu_mac.sv
// tb/tb_npu_mac.sv - Directed self-checking bench for npu_mac (default, wrapping and signed variants).
module tb_npu_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  bias;
    logic [15:0] res_d, res_w, res_s;
    logic        ovf_d, ovf_w, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npu_mac #(.DATA_W(8), .ACC_W(16), .SIGNED_MODE(1'b0), .SATURATE(1'b1)) u_dflt (
        .CLKEXT(clk), .RST_MAC(rst_n), .EN_MAC(en), .CLR_MAC(clr),
        .a(a), .b(b), .BIAS_IN(bias), .result(res_d), .OVF(ovf_d)
    );

    npu_mac #(.DATA_W(8), .ACC_W(16), .SIGNED_MODE(1'b0), .SATURATE(1'b0)) u_wrap (
        .CLKEXT(clk), .RST_MAC(rst_n), .EN_MAC(en), .CLR_MAC(clr),
        .a(a), .b(b), .BIAS_IN(bias), .result(res_w), .OVF(ovf_w)
    );

    npu_mac #(.DATA_W(8), .ACC_W(16), .SIGNED_MODE(1'b1), .SATURATE(1'b1)) u_sgn (
        .CLKEXT(clk), .RST_MAC(rst_n), .EN_MAC(en), .CLR_MAC(clr),
        .a(a), .b(b), .BIAS_IN(bias), .result(res_s), .OVF(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 8'd0; b = 8'd0; bias = 8'd10;
        #2;
        chk("reset_result", res_d, 32'd10);
        chk("reset_ovf", ovf_d, 32'd0);
        bias = 8'd5;
        #1;
        chk("reset_bias_follow", res_d, 32'd5);
        bias = 8'd10;
        step();
        chk("reset_held_over_edge", res_d, 32'd10);

        rst_n = 1'b1;
        en = 1'b1; a = 8'd3; b = 8'd4;
        step();
        chk("acc_edge1", res_d, 32'd22);
        a = 8'd2; b = 8'd5;
        step();
        chk("acc_edge2", res_d, 32'd32);

        en = 1'b0; a = 8'd9; b = 8'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_%0d", i), res_d, 32'd32);
        end

        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_result", res_d, 32'd10);
        rst_n = 1'b1;
        en = 1'b1; a = 8'd1; b = 8'd7;
        step();
        chk("after_reset_acc", res_d, 32'd17);

        clr = 1'b1; en = 1'b1; a = 8'd3; b = 8'd3;
        step();
        chk("clear_priority", res_d, 32'd10);
        clr = 1'b0;

        bias = 8'd0; en = 1'b1; a = 8'd255; b = 8'd255;
        step();
        chk("sat_edge1", res_d, 32'd65025);
        chk("sat_edge1_ovf", ovf_d, 32'd0);
        step();
        chk("sat_edge2", res_d, 32'd65535);
        chk("sat_edge2_ovf", ovf_d, 32'd1);
        chk("wrap_edge2", res_w, 32'd64514);
        chk("wrap_edge2_ovf", ovf_w, 32'd1);
        en = 1'b0;
        step();
        step();
        chk("ovf_sticky", ovf_d, 32'd1);
        bias = 8'd1;
        #1;
        chk("bias_sat", res_d, 32'd65535);
        chk("bias_wrap", res_w, 32'd64515);
        bias = 8'd0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", ovf_d, 32'd0);
        chk("clr_result", res_d, 32'd0);

        en = 1'b1; a = 8'h80; b = 8'h80;
        step();
        chk("signed_edge1", res_s, 32'd16384);
        step();
        chk("signed_clamp", res_s, 32'd32767);
        chk("signed_ovf", ovf_s, 32'd1);
        en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
